alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one registered 40-bit ALU (operands a/b, 5-bit op select s, result out) among NREQ requesters.
//   Round-robin arbitration; one operation in flight at a time.
//   Drives the ALU operand/select inputs from registers and captures the result after ALU_LAT cycles.
//   Returns the result with the winning requester's id over a valid/ready response channel.
// PARAMETERS
//   NREQ     4   number of requesters (2..8)
//   IDW      2   width of rsp_id; must equal clog2(NREQ)
//   ALU_LAT  1   edges from operands valid at ALU inputs to result valid at alu_out (0..7)
// PORTS
//   clk        in   1          single clock; all state updates on posedge
//   rst_n      in   1          asynchronous active-low reset
//   req_valid  in   NREQ       per-requester request valid
//   req_ready  out  NREQ       per-requester accept (one-hot or zero)
//   req_a      in   NREQ*40    packed operand A; slice i belongs to requester i
//   req_b      in   NREQ*40    packed operand B
//   req_op     in   NREQ*5     packed op select
//   alu_a      out  40         to ALU a
//   alu_b      out  40         to ALU b
//   alu_s      out  5          to ALU s
//   alu_out    in   40         from ALU out
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          response accept
//   rsp_id     out  IDW        requester index of the response
//   rsp_data   out  40         captured ALU result
// BEHAVIOUR
//   Reset values: req_ready=0, alu_a/alu_b=0, alu_s=0, rsp_valid=0, rsp_id=0, rsp_data=0, state=IDLE.
//   Reset pointer: last_grant=NREQ-1, so requester 0 has top priority first.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE:
//     - winner = first set req_valid bit scanning last_grant+1, +2, ... modulo NREQ.
//     - req_ready is combinational: one-hot(winner) in IDLE while any req_valid is high; 0 in every other state.
//     - Accept edge (req_valid[w] & req_ready[w]): latch req_a/b/op slice w into alu_a/b/s, latch w into rsp_id and last_grant, load cnt=ALU_LAT, go to WAIT.
//   WAIT:
//     - alu_a/b/s held stable.
//     - cnt decrements each edge.
//     - At the edge where cnt==0: capture alu_out into rsp_data, set rsp_valid=1, go to RESP.
//   Latency: rsp_valid rises exactly ALU_LAT+1 edges after the accept edge (2 for ALU_LAT=1).
//   RESP:
//     - rsp_valid, rsp_id and rsp_data held until rsp_valid & rsp_ready.
//     - On that edge: rsp_valid=0, go to IDLE. No accept occurs in the same cycle.
//   Throughput: with rsp_ready tied high, one op per ALU_LAT+3 cycles.
//   Requester rule: req_valid and the requester's operand slice stay stable until accepted. A drop before accept is legal and simply loses arbitration.
//   Boundaries:
//     - Single active requester wins every round.
//     - All requesters valid: grants go 0,1,2,3,0,...
//     - Requester i asserting in the same cycle as i's completion is not re-favoured; rotation continues from i+1.
//   alu_a/b/s retain the last operation's values while idle; no combinational path from req_* to alu_*.
//   Reset mid-operation: in-flight op discarded, no response issued, all outputs to reset values at once.
// CONFIGURATION
//   ALU_ARB_STATS_EN defined:
//     - Adds stat_ops out 32: count of rsp handshakes.
//     - Adds stat_stall out 32: count of cycles with rsp_valid & ~rsp_ready.
//     - Both saturate at 32'hFFFFFFFF and reset to 0.
//   ALU_ARB_STATS_EN undefined: both ports and counters absent; all other behaviour identical.
// TESTING
//   - Reset: rst_n=0 mid-WAIT -> all outputs 0 immediately. After release with no req_valid: req_ready=0, no rsp_valid.
//   - Single op, ALU_LAT=1: req_valid[1]=1, a=40'h000000000b, b=40'h0000000003, op=5'b00101 ->
//       req_ready=4'b0010, alu_s=5'b00101 on the next cycle,
//       rsp_valid 2 edges after accept, rsp_id=1,
//       rsp_data = standalone alu result for the same a, b, s.
//   - Fairness: all 4 req_valid held high, ops 5'b00110, 5'b01000, 5'b01011, 5'b00101 ->
//       rsp_id sequence 0,1,2,3,0, each rsp_data matching its requester's op.
//   - Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data/rsp_id stable, req_ready=0 throughout.
//       With ALU_ARB_STATS_EN: stat_stall +5 and stat_ops +1 after release.
//   - Withdrawal: req_valid[2] pulsed 1 cycle while busy -> never granted, never responded.
//   - ALU_LAT=3: rsp_valid exactly 4 edges after accept.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that time-shares one registered 40-bit
// ALU among NREQ requesters. It runs one operation at a time. The result comes
// back with the winner's id over a valid/ready response channel.
// Optional build macro: ALU_ARB_STATS_EN adds the stat_ops/stat_stall counters.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*40-1:0]   req_a,
  input  logic [NREQ*40-1:0]   req_b,
  input  logic [NREQ*5-1:0]    req_op,
  output logic [39:0]          alu_a,
  output logic [39:0]          alu_b,
  output logic [4:0]           alu_s,
  input  logic [39:0]          alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [39:0]          rsp_data
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  last_q;
  logic [2:0]      cnt_q;
  logic [39:0]     alu_a_q, alu_b_q, rsp_data_q;
  logic [4:0]      alu_s_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;

  logic [IDW-1:0]  win;
  logic [39:0]     sel_a, sel_b;
  logic [4:0]      sel_s;

  // Round-robin pick: nearest valid requester after last_q (smallest distance wins)
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (((int'(last_q) + k) % NREQ) == i)) win = IDW'(i);
      end
    end
  end

  // Operand slice of the current winner
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = req_a[i*40 +: 40];
        sel_b = req_b[i*40 +: 40];
        sel_s = req_op[i*5 +: 5];
      end
    end
  end

  // Grant is offered only while idle; held low during reset so outputs read zero at once
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && (|req_valid)) req_ready = NREQ'(1) << win;
  end

  // Control FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            alu_s_q  <= sel_s;
            rsp_id_q <= win;
            last_q   <= win;
            cnt_q    <= 3'(ALU_LAT);
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= alu_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] ops_q, ops_d, stall_q, stall_d;

  // Saturating handshake and stall counters
  always_comb begin
    ops_d   = ops_q;
    stall_d = stall_q;
    if (rsp_valid_q && rsp_ready && (ops_q != '1)) ops_d = ops_q + 32'd1;
    if (rsp_valid_q && !rsp_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  assign stat_ops   = ops_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a latency-1 instance and a latency-3 instance,
// each driving its own behavioural ALU. Results are compared with a
// round-robin reference model.
module tb_alu_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [N-1:0] req_valid, req_ready, req_valid3, req_ready3;
  logic [39:0] ta [N];
  logic [39:0] tbv [N];
  logic [4:0]  ts [N];
  logic [N*40-1:0] req_a, req_b;
  logic [N*5-1:0]  req_op;

  logic [39:0] alu_a1, alu_b1, alu_out1, rsp_data1;
  logic [4:0]  alu_s1;
  logic        rsp_valid1, rsp_ready1;
  logic [IDW-1:0] rsp_id1;
  logic [39:0] alu_a3, alu_b3, alu_out3, rsp_data3, p3a, p3b;
  logic [4:0]  alu_s3;
  logic        rsp_valid3, rsp_ready3;
  logic [IDW-1:0] rsp_id3;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_ops1, stat_stall1, stat_ops3, stat_stall3;
`endif

  int total = 0;
  int bad   = 0;
  int last_m;
  int m_ops, m_stall;

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*40 +: 40] = ta[i];
      req_b[i*40 +: 40] = tbv[i];
      req_op[i*5 +: 5]  = ts[i];
    end
  end

  alu_arbiter #(.NREQ(N), .IDW(IDW), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_out(alu_out1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1), .rsp_data(rsp_data1)
`ifdef ALU_ARB_STATS_EN
    , .stat_ops(stat_ops1), .stat_stall(stat_stall1)
`endif
  );

  alu_arbiter #(.NREQ(N), .IDW(IDW), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3), .alu_out(alu_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3)
`ifdef ALU_ARB_STATS_EN
    , .stat_ops(stat_ops3), .stat_stall(stat_stall3)
`endif
  );

  function automatic logic [39:0] alu_f(input logic [39:0] a, input logic [39:0] b,
                                        input logic [4:0] s);
    logic [39:0] r;
    case (s)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      5'd5:    r = a * b;
      5'd6:    r = a << b[5:0];
      5'd7:    r = a >> b[5:0];
      5'd8:    r = ~a;
      5'd11:   r = {a[19:0], b[19:0]};
      default: r = a + b + 40'(s);
    endcase
    return r;
  endfunction

  // Standalone registered ALUs of latency 1 and 3
  always @(posedge clk) alu_out1 <= alu_f(alu_a1, alu_b1, alu_s1);
  always @(posedge clk) begin
    p3a      <= alu_f(alu_a3, alu_b3, alu_s3);
    p3b      <= p3a;
    alu_out3 <= p3b;
  end

  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last_m + k) % N]) return (last_m + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ta[i]  = {8'($urandom), $urandom};
      tbv[i] = {8'($urandom), $urandom};
      ts[i]  = 5'($urandom_range(0, 15));
    end
  endtask

  task automatic model_reset();
    last_m  = N - 1;
    m_ops   = 0;
    m_stall = 0;
  endtask

  // One full transaction on the latency-1 instance; inputs already driven
  task automatic do_round(input int stall, input int pulse_idx, input bit drop_w,
                          output int obs_id, output time acc_t);
    int w, n;
    bit got;
    logic [39:0] expd;
    #1;
    w = model_winner(req_valid);
    total++;
    if (req_ready !== (N'(1) << w)) begin
      bad++; $display("FAIL grant: req_ready=%b want %b", req_ready, N'(1) << w);
    end
    rsp_ready1 = (stall == 0);
    @(posedge clk);
    acc_t = $time;
    #1;
    last_m = w;
    expd = alu_f(ta[w], tbv[w], ts[w]);
    total++;
    if (alu_a1 !== ta[w] || alu_b1 !== tbv[w] || alu_s1 !== ts[w]) begin
      bad++; $display("FAIL operands: a=%h b=%h s=%h want %h %h %h",
                      alu_a1, alu_b1, alu_s1, ta[w], tbv[w], ts[w]);
    end
    if (drop_w) req_valid[w] = 1'b0;
    if (pulse_idx >= 0) req_valid[pulse_idx] = 1'b1;
    got = 1'b0;
    for (n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (pulse_idx >= 0) req_valid[pulse_idx] = 1'b0;
      if (rsp_valid1) begin got = 1'b1; break; end
      total++;
      if (req_ready !== '0) begin
        bad++; $display("FAIL busy_ready: req_ready=%b want 0", req_ready);
      end
    end
    total++;
    if (!got || n != 2) begin
      bad++; $display("FAIL latency: edges=%0d got=%0d want 2", n, got);
    end
    obs_id = int'(rsp_id1);
    total++;
    if (rsp_id1 !== IDW'(w)) begin
      bad++; $display("FAIL rsp_id: got %0d want %0d", rsp_id1, w);
    end
    total++;
    if (rsp_data1 !== expd) begin
      bad++; $display("FAIL rsp_data: got %h want %h", rsp_data1, expd);
    end
    for (int s = 0; s < stall; s++) begin
      total++;
      if (req_ready !== '0) begin
        bad++; $display("FAIL stall_ready: req_ready=%b want 0", req_ready);
      end
      @(posedge clk); #1;
      total++;
      if (rsp_valid1 !== 1'b1 || rsp_id1 !== IDW'(w) || rsp_data1 !== expd) begin
        bad++; $display("FAIL hold: v=%b id=%0d d=%h want 1 %0d %h",
                        rsp_valid1, rsp_id1, rsp_data1, w, expd);
      end
    end
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    m_ops++;
    m_stall += stall;
    total++;
    if (rsp_valid1 !== 1'b0) begin
      bad++; $display("FAIL release: rsp_valid=%b want 0", rsp_valid1);
    end
`ifdef ALU_ARB_STATS_EN
    total++;
    if (stat_ops1 !== 32'(m_ops) || stat_stall1 !== 32'(m_stall)) begin
      bad++; $display("FAIL stats: ops=%0d stall=%0d want %0d %0d",
                      stat_ops1, stat_stall1, m_ops, m_stall);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_valid3 = '0; rsp_ready1 = 1'b1; rsp_ready3 = 1'b1;
    rand_ops();
    ta[2] = 40'h55_5555_5555; tbv[2] = 40'h12; ts[2] = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== '0 || alu_a1 !== '0 || alu_s1 !== '0 || rsp_valid1 !== 1'b0 ||
        rsp_id1 !== '0 || rsp_data1 !== '0 || rsp_valid3 !== 1'b0) begin
      bad++; $display("FAIL reset_state: rdy=%b a=%h s=%h v=%b id=%0d d=%h",
                      req_ready, alu_a1, alu_s1, rsp_valid1, rsp_id1, rsp_data1);
    end
    rst_n = 1'b1;
    model_reset();
    req_valid = 4'b0100;
    @(posedge clk); #1;
    total++;
    if (alu_a1 !== ta[2]) begin
      bad++; $display("FAIL pre_reset_op: a=%h want %h", alu_a1, ta[2]);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || alu_a1 !== '0 || alu_b1 !== '0 || alu_s1 !== '0 ||
        rsp_valid1 !== 1'b0 || rsp_id1 !== '0 || rsp_data1 !== '0) begin
      bad++; $display("FAIL async_reset: rdy=%b a=%h b=%h s=%h v=%b id=%0d",
                      req_ready, alu_a1, alu_b1, alu_s1, rsp_valid1, rsp_id1);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready !== '0 || rsp_valid1 !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle: rdy=%b v=%b want 0 0", req_ready, rsp_valid1);
      end
    end
  endtask

  task automatic test_single();
    int id;
    time t;
    ta[1] = 40'h00_0000_000b; tbv[1] = 40'h00_0000_0003; ts[1] = 5'b00101;
    req_valid = 4'b0010;
    do_round(0, -1, 1'b1, id, t);
  endtask

  task automatic test_fairness();
    int id;
    time t, prev;
    int seq [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    rand_ops();
    ts[0] = 5'b00110; ts[1] = 5'b01000; ts[2] = 5'b01011; ts[3] = 5'b00101;
    req_valid = 4'b1111;
    prev = 0;
    for (int r = 0; r < 5; r++) begin
      do_round(0, -1, 1'b0, id, t);
      total++;
      if (id != seq[r]) begin
        bad++; $display("FAIL rr_order: round %0d id=%0d want %0d", r, id, seq[r]);
      end
      if (r > 0) begin
        total++;
        if (t - prev != 40) begin
          bad++; $display("FAIL throughput: spacing=%0t want 40", t - prev);
        end
      end
      prev = t;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int id;
    time t;
    rand_ops();
    req_valid = 4'b0001;
    do_round(5, -1, 1'b1, id, t);
  endtask

  task automatic test_withdraw();
    int id;
    time t;
    rand_ops();
    req_valid = 4'b0001;
    do_round(0, 2, 1'b1, id, t);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid1 !== 1'b0 || req_ready !== '0) begin
        bad++; $display("FAIL withdraw_idle: v=%b rdy=%b want 0 0", rsp_valid1, req_ready);
      end
    end
    req_valid = 4'b1000;
    do_round(0, -1, 1'b1, id, t);
    total++;
    if (id != 3) begin
      bad++; $display("FAIL withdraw_next: id=%0d want 3", id);
    end
  endtask

  task automatic test_random();
    int id;
    time t;
    for (int r = 0; r < 24; r++) begin
      rand_ops();
      req_valid = N'($urandom_range(1, 15));
      do_round($urandom_range(0, 2), -1, 1'($urandom_range(0, 1)), id, t);
      req_valid = '0;
    end
  endtask

  task automatic test_lat3();
    int k, n;
    bit got;
    logic [39:0] expd;
    for (int r = 0; r < 3; r++) begin
      rand_ops();
      k = $urandom_range(0, N - 1);
      req_valid3 = N'(1) << k;
      #1;
      total++;
      if (req_ready3 !== (N'(1) << k)) begin
        bad++; $display("FAIL lat3_grant: rdy=%b want %b", req_ready3, N'(1) << k);
      end
      expd = alu_f(ta[k], tbv[k], ts[k]);
      @(posedge clk); #1;
      req_valid3 = '0;
      got = 1'b0;
      for (n = 1; n <= 12; n++) begin
        @(posedge clk); #1;
        if (rsp_valid3) begin got = 1'b1; break; end
      end
      total++;
      if (!got || n != 4) begin
        bad++; $display("FAIL lat3_latency: edges=%0d got=%0d want 4", n, got);
      end
      total++;
      if (rsp_id3 !== IDW'(k) || rsp_data3 !== expd) begin
        bad++; $display("FAIL lat3_rsp: id=%0d d=%h want %0d %h", rsp_id3, rsp_data3, k, expd);
      end
      @(posedge clk); #1;
      total++;
      if (rsp_valid3 !== 1'b0) begin
        bad++; $display("FAIL lat3_release: v=%b want 0", rsp_valid3);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_withdraw();
    test_random();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
